// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner.
// One-hot debounce FSM states and the button priority order.
package button_conditioner_pkg;

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        WQ   = 5'b00010,
        SCEN = 5'b00100,
        HELD = 5'b01000,
        WR   = 5'b10000
    } state_t;

    // Bit index doubles as priority: lower index wins.
    localparam int BTN_U   = 0;
    localparam int BTN_D   = 1;
    localparam int BTN_R   = 2;
    localparam int BTN_L   = 3;
    localparam int BTN_C   = 4;
    localparam int NUM_BTN = 5;

endpackage

// File: rtl/button_conditioner_debounce.sv
// Single-button synchroniser, debounce FSM, press pulse and level.
// Outputs are decoded from the state register only.
module btn_debounce_one #(
    parameter int DEBOUNCE_CNT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic scen,
    output logic db
);
    import button_conditioner_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_CNT);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          s1;
    logic          s2;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Debounce FSM: require a quiet window on both press and release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s2) begin
                        cnt   <= '0;
                        state <= WQ;
                    end
                end
                WQ: begin
                    if (!s2) begin
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        state <= SCEN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SCEN: begin
                    state <= HELD;
                end
                HELD: begin
                    if (!s2) begin
                        cnt   <= '0;
                        state <= WR;
                    end
                end
                WR: begin
                    if (s2) begin
                        state <= HELD;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign scen = (state == SCEN);
    assign db   = (state == SCEN) || (state == HELD) || (state == WR);

endmodule

// File: rtl/button_conditioner.sv
// Five-button conditioner: per-button debounce plus optional
// one-pulse-per-cycle priority filter (U > D > R > L > C).
module button_conditioner #(
    parameter int DEBOUNCE_CNT = 1000000,
    parameter int MUTEX        = 1
) (
    input  logic Clk,
    input  logic reset,
    input  logic BtnL_raw,
    input  logic BtnR_raw,
    input  logic BtnU_raw,
    input  logic BtnD_raw,
    input  logic BtnC_raw,
    output logic BtnL_scen,
    output logic BtnR_scen,
    output logic BtnU_scen,
    output logic BtnD_scen,
    output logic BtnC_scen,
    output logic BtnL_db,
    output logic BtnR_db,
    output logic BtnU_db,
    output logic BtnD_db,
    output logic BtnC_db,
    output logic Collision
);
    import button_conditioner_pkg::*;

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] scen_i;
    logic [NUM_BTN-1:0] db_vec;
    logic [NUM_BTN-1:0] scen_vec;

    assign raw_vec[BTN_U] = BtnU_raw;
    assign raw_vec[BTN_D] = BtnD_raw;
    assign raw_vec[BTN_R] = BtnR_raw;
    assign raw_vec[BTN_L] = BtnL_raw;
    assign raw_vec[BTN_C] = BtnC_raw;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce_one #(
            .DEBOUNCE_CNT(DEBOUNCE_CNT)
        ) u_db (
            .clk (Clk),
            .rst (reset),
            .raw (raw_vec[i]),
            .scen(scen_i[i]),
            .db  (db_vec[i])
        );
    end

    if (MUTEX != 0) begin : g_mutex
        logic [NUM_BTN-1:0] win;
        logic               found;

        // Keep only the highest-priority pulse; losers are dropped.
        always_comb begin
            win   = '0;
            found = 1'b0;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (scen_i[i] && !found) begin
                    win[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end

        assign scen_vec  = win;
        assign Collision = |(scen_i & ~win);
    end else begin : g_pass
        assign scen_vec  = scen_i;
        assign Collision = 1'b0;
    end

    assign BtnU_scen = scen_vec[BTN_U];
    assign BtnD_scen = scen_vec[BTN_D];
    assign BtnR_scen = scen_vec[BTN_R];
    assign BtnL_scen = scen_vec[BTN_L];
    assign BtnC_scen = scen_vec[BTN_C];

    assign BtnU_db = db_vec[BTN_U];
    assign BtnD_db = db_vec[BTN_D];
    assign BtnR_db = db_vec[BTN_R];
    assign BtnL_db = db_vec[BTN_L];
    assign BtnC_db = db_vec[BTN_C];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner, DEBOUNCE_CNT=4.
// A MUTEX=1 and a MUTEX=0 instance share the raw inputs.
module tb_button_conditioner;

    logic Clk = 1'b0;
    logic reset;
    logic BtnL_raw, BtnR_raw, BtnU_raw, BtnD_raw, BtnC_raw;

    logic L_s, R_s, U_s, D_s, C_s;
    logic L_d, R_d, U_d, D_d, C_d;
    logic col;
    logic L_s0, R_s0, U_s0, D_s0, C_s0;
    logic L_d0, R_d0, U_d0, D_d0, C_d0;
    logic col0;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    button_conditioner #(.DEBOUNCE_CNT(4), .MUTEX(1)) dut (
        .Clk(Clk), .reset(reset),
        .BtnL_raw(BtnL_raw), .BtnR_raw(BtnR_raw),
        .BtnU_raw(BtnU_raw), .BtnD_raw(BtnD_raw),
        .BtnC_raw(BtnC_raw),
        .BtnL_scen(L_s), .BtnR_scen(R_s), .BtnU_scen(U_s),
        .BtnD_scen(D_s), .BtnC_scen(C_s),
        .BtnL_db(L_d), .BtnR_db(R_d), .BtnU_db(U_d),
        .BtnD_db(D_d), .BtnC_db(C_d),
        .Collision(col)
    );

    button_conditioner #(.DEBOUNCE_CNT(4), .MUTEX(0)) dut0 (
        .Clk(Clk), .reset(reset),
        .BtnL_raw(BtnL_raw), .BtnR_raw(BtnR_raw),
        .BtnU_raw(BtnU_raw), .BtnD_raw(BtnD_raw),
        .BtnC_raw(BtnC_raw),
        .BtnL_scen(L_s0), .BtnR_scen(R_s0), .BtnU_scen(U_s0),
        .BtnD_scen(D_s0), .BtnC_scen(C_s0),
        .BtnL_db(L_d0), .BtnR_db(R_d0), .BtnU_db(U_d0),
        .BtnD_db(D_d0), .BtnC_db(C_d0),
        .Collision(col0)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; outputs are settled afterwards.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        logic [15:0] v;
        v = {L_s, R_s, U_s, D_s, C_s, L_d, R_d, U_d, D_d, C_d, col,
             L_s0, U_s0, D_s0, C_s0, U_d0};
        for (int i = 0; i < 16; i++) check(tag, v[i], 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        {BtnL_raw, BtnR_raw, BtnU_raw, BtnD_raw, BtnC_raw} = '0;
        tick();
        tick();
        check_all_zero("reset_state");
        reset = 1'b0;
        tick();
        tick();

        // Clean press on U, held 20 cycles.
        BtnU_raw = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("clean_U_scen", U_s, k == 6);
            check("clean_U_db", U_d, k >= 6);
            check("clean_col", col, 1'b0);
        end
        BtnU_raw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("clean_U_rel_db", U_d, k < 6);
            check("clean_U_rel_scen", U_s, 1'b0);
        end

        // Press bounce on R: 2 high, 1 low, 2 high, low.
        for (int k = 0; k < 12; k++) begin
            BtnR_raw = (k == 0 || k == 1 || k == 3 || k == 4);
            tick();
            check("bounce_R_scen", R_s, 1'b0);
            check("bounce_R_db", R_d, 1'b0);
        end
        BtnR_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("steady_R_scen", R_s, k == 6);
            check("steady_R_db", R_d, k >= 6);
        end
        BtnR_raw = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("steady_R_rel_db", R_d, 1'b0);

        // Release bounce on D: low 2, high 1, then low for good.
        BtnD_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("relb_D_press_scen", D_s, k == 6);
        end
        for (int k = 0; k < 12; k++) begin
            BtnD_raw = (k == 2);
            tick();
            check("relb_D_db", D_d, k < 9);
            check("relb_D_scen", D_s, 1'b0);
        end

        // Simultaneous U and D presses.
        BtnU_raw = 1'b1;
        BtnD_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("col_U_scen", U_s, k == 6);
            check("col_D_scen", D_s, 1'b0);
            check("col_flag", col, k == 6);
            check("col_U_db", U_d, k >= 6);
            check("col_D_db", D_d, k >= 6);
            check("nomutex_U_scen", U_s0, k == 6);
            check("nomutex_D_scen", D_s0, k == 6);
            check("nomutex_col", col0, 1'b0);
        end
        BtnU_raw = 1'b0;
        BtnD_raw = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("col_rel_U_db", U_d, 1'b0);
        check("col_rel_D_db", D_d, 1'b0);

        // Reset while C sits in WQ with cnt=2.
        BtnC_raw = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rst_C_pre_db", C_d, 1'b0);
        end
        reset = 1'b1;
        #1;
        check_all_zero("rst_async");
        tick();
        check_all_zero("rst_hold");
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("rst_C_scen", C_s, k == 6);
            check("rst_C_db", C_d, k >= 6);
        end

        // L pressed while C stays in HELD.
        BtnL_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("ind_L_scen", L_s, k == 6);
            check("ind_L_db", L_d, k >= 6);
            check("ind_col", col, 1'b0);
            check("ind_C_db", C_d, 1'b1);
            check("ind_C_scen", C_s, 1'b0);
        end
        BtnL_raw = 1'b0;
        BtnC_raw = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("final_L_db", L_d, 1'b0);
        check("final_C_db", C_d, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream stage between the five raw board pushbuttons and the game controller.
- Per button: synchronises the raw input, debounces it, and produces a debounced level plus a single-clock enable pulse (SCEN) once per press.
- The game controller consumes the SCEN pulses as BtnL/BtnR/BtnU/BtnD/BtnC. An optional mutual-exclusion stage guarantees at most one SCEN per cycle.

Parameters:
- DEBOUNCE_CNT, 1000000, stable cycles required on press and on release (10 ms at 100 MHz); legal range >= 2.
- MUTEX, 1, 1 = at most one SCEN output per cycle (priority U > D > R > L > C); 0 = pulses pass unfiltered.

Ports:
- Clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- BtnL_raw, BtnR_raw, BtnU_raw, BtnD_raw, BtnC_raw  in  1 each  raw asynchronous pushbutton inputs, 1 = pressed
- BtnL_scen, BtnR_scen, BtnU_scen, BtnD_scen, BtnC_scen  out  1 each  one-cycle press pulse
- BtnL_db, BtnR_db, BtnU_db, BtnD_db, BtnC_db  out  1 each  debounced pressed level
- Collision  out  1  one-cycle flag: MUTEX=1 dropped at least one SCEN this cycle

Behaviour:
- Clock, reset and counter:
  - One clock Clk; reset is asynchronous and active-high.
  - Reset forces every state to IDLE, synchroniser flops to 0, counters to 0, and all outputs to 0.
  - Reset mid-press returns the block to IDLE. A button still held after reset release generates a new SCEN after the full debounce time.
  - Counter width is clog2(DEBOUNCE_CNT), unsigned. The counter never wraps, because the compare at DEBOUNCE_CNT-1 always exits the counting state.
- Per button (sub-module):
  - Two-flop synchroniser: s1 <= raw; s2 <= s1.
  - The FSM acts on s2 only.
- FSM states: IDLE, WQ (wait quiet on press), SCEN, HELD, WR (wait quiet on release).
  - IDLE: if s2, cnt <= 0 and go to WQ.
  - WQ: if !s2, go to IDLE (bounce rejected). Else if cnt == DEBOUNCE_CNT-1, go to SCEN. Else cnt <= cnt+1.
  - SCEN: lasts exactly one cycle, then go to HELD unconditionally.
  - HELD: if !s2, cnt <= 0 and go to WR.
  - WR: if s2, go to HELD (release bounce, no new pulse). Else if cnt == DEBOUNCE_CNT-1, go to IDLE. Else cnt <= cnt+1.
- Outputs are Moore:
  - scen_i = (state == SCEN).
  - db = state in {SCEN, HELD, WR}.
- Latency:
  - Raw is sampled high at edge 0 and held. The FSM enters SCEN after edge DEBOUNCE_CNT+2, so SCEN is high for the following single cycle.
  - db rises in the same cycle as SCEN.
  - Release is sampled at edge r. db falls after edge r+DEBOUNCE_CNT+2.
- Holding a button indefinitely yields exactly one SCEN; there is no auto-repeat.
- Mutual exclusion:
  - MUTEX=1: if two or more scen_i are high in a cycle, only the highest-priority one (U > D > R > L > C) appears on *_scen. The others are dropped, not deferred, and Collision = 1 that cycle.
  - MUTEX=0: *_scen = scen_i, and Collision is tied to 0.
  - The mutex stage is combinational on registered FSM state, so it adds zero latency.
  - *_db outputs are never filtered.

Decomposition:
- Shared package: FSM state encoding constants (IDLE, WQ, SCEN, HELD, WR; one-hot, 5 bits, matching the team's one-hot state style) and the button priority order constants.
- One natural sub-module: btn_debounce_one (synchroniser, counter, FSM, scen/db outputs).
  - The top instantiates it five times and adds the priority/collision logic.

Test Plan (DEBOUNCE_CNT=4 for simulation):
- Clean press: BtnU_raw high from edge 0 and held 20 cycles -> BtnU_scen high only in the cycle after edge 6; BtnU_db high from that cycle; no second pulse.
- Press bounce: BtnR_raw high 2 cycles, low 1, high 2, low -> no BtnR_scen and BtnR_db stays 0. Then a steady press -> pulse 6 edges after the steady high.
- Release bounce: after a valid press, raw low 2 cycles, high 1, then low -> BtnD_db stays 1 through the bounce and falls 6 edges after the final low; no extra pulse.
- Collision: BtnU_raw and BtnD_raw rise on the same edge (MUTEX=1) -> only BtnU_scen pulses and Collision = 1 for that cycle; both *_db go high. With MUTEX=0, both pulse and Collision = 0.
- Reset mid-operation: assert reset while BtnC is in WQ with cnt=2, release reset with raw still high -> all outputs 0 during reset; BtnC_scen fires 6 edges after reset deassertion.
- Independence: BtnL pressed while BtnC is held in HELD -> BtnL_scen pulses normally with Collision = 0, since BtnC is not in SCEN; BtnC_db stays 1.
